// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver.
//   ps2_state_t : frame FSM state encoding (exported on the debug port)
//   PREFIX_EXT  : scancode prefix announcing an extended key (E0)
//   PREFIX_REL  : scancode prefix announcing a key release (F0)
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_t;

   localparam logic [7:0] PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PREFIX_REL = 8'hF0;

endpackage

// File: rtl/ps2_filter.sv
// Conditions one asynchronous PS/2 line: a 2-flop synchronizer, a glitch
// filter that moves the filtered level only after FILTER_LEN consecutive
// synchronized samples disagree with it, and a falling-edge strobe.
//   clk    : system clock
//   reset  : synchronous active-high reset, line state returns to idle (1)
//   line   : raw asynchronous input
//   sync   : synchronized (unfiltered) line
//   level  : filtered line level
//   fall   : one-cycle strobe, filtered level just went high -> low
module ps2_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic line,
   output logic sync,
   output logic level,
   output logic fall
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic          meta;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta  <= 1'b1;
         sync  <= 1'b1;
         level <= 1'b1;
         fall  <= 1'b0;
         cnt   <= '0;
      end else begin
         meta <= line;
         sync <= meta;
         fall <= 1'b0;
         // cnt counts how many samples in a row have disagreed with level;
         // any agreeing sample restarts the run, so short glitches vanish.
         if (sync == level) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER_LEN - 1)) begin
            level <= sync;
            fall  <= level;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frames 11-bit PS/2 words into bytes and decodes
// the E0/F0 prefixes into key events.
//   clk, reset          : system clock, synchronous active-high reset
//   ps2_clk, ps2_data   : asynchronous PS/2 lines (idle high)
//   raw_byte, raw_valid : last accepted frame byte and its one-cycle strobe
//   frame_err           : one-cycle strobe, frame rejected or timed out
//   key_code, key_ext, key_release, key_valid : decoded key event
//   fsm_state           : debug view of the frame FSM
// Strobes are single-cycle pulses with no ready/backpressure: a consumer
// must capture the associated data in the cycle the strobe is high; the
// data itself is held until the next strobe of the same kind.
module ps2_kbd_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] raw_byte,
   output logic       raw_valid,
   output logic       frame_err,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_release,
   output logic       key_valid,
   output ps2_state_t fsm_state
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic clk_sync, clk_level, clk_fall;
   logic data_sync, data_level, data_fall;

   ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .clk(clk), .reset(reset), .line(ps2_clk),
      .sync(clk_sync), .level(clk_level), .fall(clk_fall)
   );

   ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
      .clk(clk), .reset(reset), .line(ps2_data),
      .sync(data_sync), .level(data_level), .fall(data_fall)
   );

   // Only the filtered clock edge and the synchronized data are consumed.
   logic unused_lines;
   assign unused_lines = clk_sync ^ clk_level ^ data_level ^ data_fall;

   ps2_state_t    state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          parity;
   logic [TW-1:0] tcnt;
   logic          ext_pend, rel_pend;

   assign fsm_state = state;

   // Frame FSM: advances once per filtered falling edge of ps2_clk.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         parity    <= 1'b0;
         tcnt      <= '0;
         raw_byte  <= '0;
         raw_valid <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         raw_valid <= 1'b0;
         frame_err <= 1'b0;
         if (clk_fall) begin
            tcnt <= '0;
            case (state)
               ST_IDLE: begin
                  if (!data_sync) begin
                     state   <= ST_DATA;
                     bit_cnt <= '0;
                     shreg   <= '0;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
               ST_DATA: begin
                  shreg   <= {data_sync, shreg[7:1]};   // LSB arrives first
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= ST_PARITY;
               end
               ST_PARITY: begin
                  parity <= data_sync;
                  state  <= ST_STOP;
               end
               ST_STOP: begin
                  state <= ST_IDLE;
                  // Odd parity over data+parity and a high stop bit.
                  if (data_sync && (^shreg ^ parity)) begin
                     raw_byte  <= shreg;
                     raw_valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end else if (state != ST_IDLE) begin
            // Abort a stalled frame; the >= keeps the count from wrapping.
            if (tcnt >= TW'(TIMEOUT - 1)) begin
               frame_err <= 1'b1;
               state     <= ST_IDLE;
               tcnt      <= '0;
            end else begin
               tcnt <= tcnt + 1'b1;
            end
         end else begin
            tcnt <= '0;
         end
      end
   end

   // Prefix decoder: one cycle behind raw_valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         ext_pend    <= 1'b0;
         rel_pend    <= 1'b0;
         key_code    <= '0;
         key_ext     <= 1'b0;
         key_release <= 1'b0;
         key_valid   <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         if (frame_err) begin
            ext_pend <= 1'b0;
            rel_pend <= 1'b0;
         end else if (raw_valid) begin
            if (raw_byte == PREFIX_EXT) begin
               ext_pend <= 1'b1;
            end else if (raw_byte == PREFIX_REL) begin
               rel_pend <= 1'b1;
            end else begin
               key_code    <= raw_byte;
               key_ext     <= ext_pend;
               key_release <= rel_pend;
               key_valid   <= 1'b1;
               ext_pend    <= 1'b0;
               rel_pend    <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: table of whole frames plus hand-written
// sequences for glitches, bad start bit, timeout and reset mid-frame.
module tb_ps2_kbd_rx;
   import ps2_pkg::*;

   localparam int FL   = 8;
   localparam int TO   = 200;
   localparam int HALF = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] raw_byte, key_code;
   logic       raw_valid, frame_err, key_ext, key_release, key_valid;
   ps2_state_t fsm_state;

   ps2_kbd_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .raw_byte(raw_byte), .raw_valid(raw_valid), .frame_err(frame_err),
      .key_code(key_code), .key_ext(key_ext), .key_release(key_release),
      .key_valid(key_valid), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   // ---------------- monitor ----------------
   int n_cmp = 0, n_fail = 0;
   int cyc = 0, raw_n = 0, err_n = 0, key_n = 0, both_n = 0, stab_n = 0;
   int raw_cyc = 0, key_cyc = 0;
   logic [9:0] prev_key = '0;

   always @(posedge clk) begin
      #1;
      cyc++;
      if (raw_valid) begin raw_n++; raw_cyc = cyc; end
      if (frame_err) err_n++;
      if (raw_valid && frame_err) both_n++;
      if (key_valid) begin key_n++; key_cyc = cyc; end
      if (!reset && !key_valid && ({key_code, key_ext, key_release} != prev_key))
         stab_n++;
      prev_key = {key_code, key_ext, key_release};
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [10:0] make_frame(input logic [7:0] d, input logic pflip,
                                              input logic stop);
      return {stop, (~^d) ^ pflip, d, 1'b0};
   endfunction

   task automatic ps2_bit(input logic b);
      @(negedge clk) ps2_data = b;
      repeat (HALF / 2) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF / 2) @(negedge clk);
   endtask

   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) ps2_bit(f[i]);
      ps2_data = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop);
      send_bits(make_frame(d, pflip, stop), 11);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0] data;
      logic       pflip;
      logic       stop;
      int         d_raw, d_err, d_key;
      logic [7:0] e_raw, e_code;
      logic       e_ext, e_rel;
   } vec_t;

   vec_t vecs[11];
   int r0, e0, k0;

   initial begin
      vecs[0]  = '{8'h1C, 1'b0, 1'b1, 1, 0, 1, 8'h1C, 8'h1C, 1'b0, 1'b0};
      vecs[1]  = '{8'hE0, 1'b0, 1'b1, 1, 0, 0, 8'hE0, 8'h1C, 1'b0, 1'b0};
      vecs[2]  = '{8'hF0, 1'b0, 1'b1, 1, 0, 0, 8'hF0, 8'h1C, 1'b0, 1'b0};
      vecs[3]  = '{8'h74, 1'b0, 1'b1, 1, 0, 1, 8'h74, 8'h74, 1'b1, 1'b1};
      vecs[4]  = '{8'h1C, 1'b1, 1'b1, 0, 1, 0, 8'h74, 8'h74, 1'b1, 1'b1};
      vecs[5]  = '{8'h1C, 1'b0, 1'b0, 0, 1, 0, 8'h74, 8'h74, 1'b1, 1'b1};
      vecs[6]  = '{8'hF0, 1'b0, 1'b1, 1, 0, 0, 8'hF0, 8'h74, 1'b1, 1'b1};
      vecs[7]  = '{8'h33, 1'b1, 1'b1, 0, 1, 0, 8'hF0, 8'h74, 1'b1, 1'b1};
      vecs[8]  = '{8'h12, 1'b0, 1'b1, 1, 0, 1, 8'h12, 8'h12, 1'b0, 1'b0};
      vecs[9]  = '{8'hE0, 1'b0, 1'b1, 1, 0, 0, 8'hE0, 8'h12, 1'b0, 1'b0};
      vecs[10] = '{8'h75, 1'b0, 1'b1, 1, 0, 1, 8'h75, 8'h75, 1'b1, 1'b0};

      // clock/reset
      repeat (5) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_raw_byte", raw_byte, 8'h00);
      check("rst_key", {key_code, key_ext, key_release}, 10'h000);
      check("rst_strobes", {raw_valid, frame_err, key_valid}, 3'b000);
      check("rst_state", fsm_state, ST_IDLE);

      // short ps2_clk glitches while idle
      r0 = raw_n; e0 = err_n; k0 = key_n;
      for (int g = 0; g < 4; g++) begin
         @(negedge clk) ps2_clk = 1'b0;
         repeat (FL - 2) @(negedge clk);
         ps2_clk = 1'b1;
         repeat (20) @(negedge clk);
      end
      check("glitch_strobes", (raw_n - r0) + (err_n - e0) + (key_n - k0), 0);
      check("glitch_state", fsm_state, ST_IDLE);

      // table-driven frames
      for (int v = 0; v < 11; v++) begin
         r0 = raw_n; e0 = err_n; k0 = key_n;
         send_frame(vecs[v].data, vecs[v].pflip, vecs[v].stop);
         check($sformatf("v%0d_raw_cnt", v), raw_n - r0, vecs[v].d_raw);
         check($sformatf("v%0d_err_cnt", v), err_n - e0, vecs[v].d_err);
         check($sformatf("v%0d_key_cnt", v), key_n - k0, vecs[v].d_key);
         check($sformatf("v%0d_raw_byte", v), raw_byte, vecs[v].e_raw);
         check($sformatf("v%0d_key", v), {key_code, key_ext, key_release},
               {vecs[v].e_code, vecs[v].e_ext, vecs[v].e_rel});
         if (vecs[v].d_key == 1)
            check($sformatf("v%0d_key_latency", v), key_cyc - raw_cyc, 1);
      end

      // a 1 sampled as start bit
      r0 = raw_n; e0 = err_n;
      send_bits(11'h7FF, 1);
      check("badstart_err", err_n - e0, 1);
      check("badstart_raw", raw_n - r0, 0);
      check("badstart_state", fsm_state, ST_IDLE);

      // start + 4 data bits, then the clock stalls
      r0 = raw_n; e0 = err_n;
      send_bits(make_frame(8'h55, 1'b0, 1'b1), 5);
      repeat (TO + 20) @(negedge clk);
      check("timeout_err", err_n - e0, 1);
      check("timeout_raw", raw_n - r0, 0);
      check("timeout_state", fsm_state, ST_IDLE);
      send_frame(8'h2A, 1'b0, 1'b1);
      check("after_timeout_byte", raw_byte, 8'h2A);
      check("after_timeout_err", err_n - e0, 1);

      // reset in the middle of a frame, with a release prefix pending
      send_frame(8'hF0, 1'b0, 1'b1);
      r0 = raw_n; e0 = err_n; k0 = key_n;
      send_bits(make_frame(8'h3C, 1'b0, 1'b1), 6);
      @(negedge clk) reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_strobes", (raw_n - r0) + (err_n - e0) + (key_n - k0), 0);
      check("midrst_outputs", {raw_byte, key_code, key_ext, key_release}, 18'h0);
      check("midrst_state", fsm_state, ST_IDLE);
      send_frame(8'h15, 1'b0, 1'b1);
      check("postrst_raw_byte", raw_byte, 8'h15);
      check("postrst_key", {key_code, key_ext, key_release}, {8'h15, 1'b0, 1'b0});
      check("postrst_counts", {raw_n - r0, err_n - e0, key_n - k0}, {32'd1, 32'd0, 32'd1});

      // whole-run invariants
      check("raw_and_err_same_cycle", both_n, 0);
      check("key_fields_stable", stab_n, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
